// File: rtl/otter_if_pkg.sv
// Shared types and constants for the OTTER instruction-fetch stage.
// The IF/ID entry struct, buffer depth and the empty-head NOP live here.
package otter_if_pkg;

  localparam int          IF_BUF_DEPTH = 2;
  localparam int          IF_CNT_W     = $clog2(IF_BUF_DEPTH + 1);
  localparam logic [31:0] IF_INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] ir;
  } if_entry_t;

  // Instructions are word aligned; drop the byte offset.
  function automatic logic [31:0] pc_align(input logic [31:0] pc);
    return pc & ~32'h3;
  endfunction

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/otter_if_buf.sv
// Small shift-register FIFO holding fetched IF/ID entries; slot 0 is the head.
// Flush beats push/pop; simultaneous push and pop is legal at any fill level.
module otter_if_buf
  import otter_if_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic                flush,
  input  if_entry_t           entry_in,
  output if_entry_t           entry_out,
  output logic [IF_CNT_W-1:0] count
);

  localparam logic [IF_CNT_W-1:0] DEPTH_C = IF_CNT_W'(IF_BUF_DEPTH);

  if_entry_t [IF_BUF_DEPTH-1:0] mem_q, mem_d;
  logic [IF_CNT_W-1:0]          count_q, count_d;
  logic [IF_CNT_W-1:0]          wr_idx;
  logic                         pop_ok, push_ok;

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != '0);
    wr_idx  = count_q - {{(IF_CNT_W-1){1'b0}}, pop_ok};
    push_ok = push && (wr_idx < DEPTH_C);
    if (flush) begin
      mem_d   = '0;
      count_d = '0;
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < IF_BUF_DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
        mem_d[IF_BUF_DEPTH-1] = '0;
      end
      // Write lands after the shift, so a push at full-with-pop fills the vacated tail.
      if (push_ok) mem_d[wr_idx] = entry_in;
      count_d = wr_idx + {{(IF_CNT_W-1){1'b0}}, push_ok};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q   <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      count_q <= count_d;
    end
  end

  assign entry_out = mem_q[0];
  assign count     = count_q;

endmodule

// File: rtl/otter_if_stage.sv
// OTTER fetch stage: issues one instruction read per cycle into a 2-entry
// IF/ID buffer, with redirect flush/squash and PC register control.
module otter_if_stage
  import otter_if_pkg::*;
(
  input  logic        IF_CLK,
  input  logic        IF_RST,
  input  logic [31:0] IF_PC,
  output logic        IF_PC_LD,
  output logic [31:0] IF_PC_NEXT,
  output logic        IF_MEM_RDEN,
  output logic [31:0] IF_MEM_ADDR,
  input  logic [31:0] IF_MEM_DATA,
  input  logic        IF_REDIR,
  input  logic [31:0] IF_REDIR_PC,
  input  logic        IF_ID_READY,
  output logic        IF_ID_VALID,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_IR,
  output logic        IF_MISALIGN
);

  logic                inflight_q, inflight_d;
  logic [31:0]         issued_pc_q, issued_pc_d;
  logic [IF_CNT_W-1:0] count;
  if_entry_t           head, push_entry;
  logic                has_entry, redir, pop, push, issue;
  logic [IF_CNT_W:0]   occupancy, limit;

  assign has_entry = (count != '0);
  assign redir     = IF_REDIR && !IF_RST;
  assign pop       = has_entry && IF_ID_READY && !IF_REDIR && !IF_RST;
  // A redirect squashes the response landing this cycle.
  assign push      = inflight_q && !IF_REDIR && !IF_RST;

  // Buffered + in-flight words must leave room for the one being requested.
  assign occupancy = {1'b0, count} + {{IF_CNT_W{1'b0}}, inflight_q};
  assign limit     = (IF_CNT_W+1)'(IF_BUF_DEPTH) + {{IF_CNT_W{1'b0}}, pop};
  assign issue     = !IF_RST && !IF_REDIR && (occupancy < limit);

  assign push_entry.pc  = issued_pc_q;
  assign push_entry.pc4 = pc_inc(issued_pc_q);
  assign push_entry.ir  = IF_MEM_DATA;

  otter_if_buf u_buf (
    .clk       (IF_CLK),
    .rst       (IF_RST),
    .push      (push),
    .pop       (pop),
    .flush     (redir),
    .entry_in  (push_entry),
    .entry_out (head),
    .count     (count)
  );

  always_comb begin
    inflight_d  = issue;
    issued_pc_d = issue ? IF_PC : issued_pc_q;
  end

  always_ff @(posedge IF_CLK) begin
    if (IF_RST) begin
      inflight_q  <= 1'b0;
      issued_pc_q <= '0;
    end else begin
      inflight_q  <= inflight_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  always_comb begin
    IF_PC_LD    = 1'b0;
    IF_PC_NEXT  = IF_PC;
    IF_MEM_RDEN = 1'b0;
    IF_MEM_ADDR = IF_PC;
    IF_ID_VALID = has_entry;
    IF_ID_PC    = head.pc;
    IF_ID_PC4   = head.pc4;
    IF_ID_IR    = has_entry ? head.ir : IF_INSTR_NOP;
    IF_MISALIGN = 1'b0;
    if (IF_RST) begin
      IF_PC_NEXT  = '0;
      IF_MEM_ADDR = '0;
      IF_ID_VALID = 1'b0;
      IF_ID_PC    = '0;
      IF_ID_PC4   = '0;
      IF_ID_IR    = '0;
    end else if (redir) begin
      IF_PC_LD    = 1'b1;
      IF_PC_NEXT  = pc_align(IF_REDIR_PC);
      IF_ID_VALID = 1'b0;
      IF_MISALIGN = (IF_REDIR_PC[1:0] != 2'b00);
    end else if (issue) begin
      IF_PC_LD    = 1'b1;
      IF_PC_NEXT  = pc_inc(IF_PC);
      IF_MEM_RDEN = 1'b1;
    end
  end

endmodule
